// File: rtl/adc_freq_meter.sv
// Hysteresis squarer and gated rising-edge counter for the AD9481 sample stream.
// Optional period measurement between successive rising edges: define FREQ_PERIOD_MEAS_EN.
module adc_freq_meter #(
  parameter int DATA_W      = 8,
  parameter int MID         = 128,
  parameter int HYST        = 8,
  parameter int GATE_CYCLES = 250000000,
  parameter int CNT_W       = 28
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              sample_en,
  output logic              square_out,
  output logic [CNT_W-1:0]  freq_count,
  output logic              freq_valid,
  output logic              overflow,
  output logic [CNT_W-1:0]  period_cycles,
  output logic              period_valid
);

  localparam int MAX_CODE = (1 << DATA_W) - 1;
  localparam int TH_HI_I  = (MID + HYST > MAX_CODE) ? MAX_CODE : (MID + HYST);
  localparam int TH_LO_I  = (MID - HYST < 0) ? 0 : (MID - HYST);
  localparam logic [DATA_W-1:0] TH_HI = DATA_W'(TH_HI_I);
  localparam logic [DATA_W-1:0] TH_LO = DATA_W'(TH_LO_I);
  localparam logic [CNT_W-1:0]  GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {ARM, GATE, LATCH} state_t;

  state_t           r_state;
  logic             r_square;
  logic             r_square_d;
  logic [CNT_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf_flag;
  logic [CNT_W-1:0] r_freq_count;
  logic             r_freq_valid;
  logic             r_overflow;
  logic             w_rise;

  // Saturating increment: sticks at the all-ones code instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_square   <= 1'b0;
      r_square_d <= 1'b0;
    end else begin
      r_square_d <= r_square;
      if (sample_en) begin
        if (adc_data >= TH_HI)
          r_square <= 1'b1;
        else if (adc_data <= TH_LO)
          r_square <= 1'b0;
      end
    end
  end

  assign w_rise = r_square & ~r_square_d;

  // ARM waits for a start edge (reporting 0 once per gate meanwhile); GATE/LATCH then run back-to-back.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= ARM;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf_flag   <= 1'b0;
      r_freq_count <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      case (r_state)
        ARM: begin
          if (w_rise) begin
            r_state    <= GATE;
            r_gate_cnt <= CNT_ONE;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
          end else if (r_gate_cnt == GATE_LAST) begin
            r_freq_count <= '0;
            r_overflow   <= 1'b0;
            r_freq_valid <= 1'b1;
            r_gate_cnt   <= '0;
          end else begin
            r_gate_cnt <= r_gate_cnt + CNT_ONE;
          end
        end
        GATE: begin
          r_gate_cnt <= r_gate_cnt + CNT_ONE;
          if (w_rise) begin
            if (r_edge_cnt == CNT_MAX)
              r_ovf_flag <= 1'b1;
            r_edge_cnt <= sat_inc(r_edge_cnt);
          end
          if (r_gate_cnt == GATE_LAST)
            r_state <= LATCH;
        end
        LATCH: begin
          r_freq_count <= r_edge_cnt;
          r_overflow   <= r_ovf_flag;
          r_freq_valid <= 1'b1;
          // An edge arriving here belongs to the gate that starts now.
          r_edge_cnt   <= {{(CNT_W-1){1'b0}}, w_rise};
          r_ovf_flag   <= 1'b0;
          r_gate_cnt   <= CNT_ONE;
          r_state      <= GATE;
        end
        default: begin
          r_state    <= ARM;
          r_gate_cnt <= '0;
        end
      endcase
    end
  end

  assign square_out = r_square;
  assign freq_count = r_freq_count;
  assign freq_valid = r_freq_valid;
  assign overflow   = r_overflow;

`ifdef FREQ_PERIOD_MEAS_EN
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_per_armed;
  logic             r_per_vld;

  // Counter restarts at 1 on every edge so its value at the next edge equals the edge spacing.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_per_cnt   <= '0;
      r_period    <= '0;
      r_per_armed <= 1'b0;
      r_per_vld   <= 1'b0;
    end else begin
      r_per_vld <= 1'b0;
      if (r_state == ARM) begin
        r_per_cnt   <= w_rise ? CNT_ONE : '0;
        r_per_armed <= w_rise;
      end else if (w_rise) begin
        r_per_cnt   <= CNT_ONE;
        r_per_armed <= 1'b1;
        if (r_per_armed) begin
          r_period  <= r_per_cnt;
          r_per_vld <= 1'b1;
        end
      end else begin
        r_per_cnt <= sat_inc(r_per_cnt);
      end
    end
  end

  assign period_cycles = r_period;
  assign period_valid  = r_per_vld;
`else
  assign period_cycles = '0;
  assign period_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_adc_freq_meter.sv
// Scoreboard bench for adc_freq_meter with a 1000-cycle gate and directed stimulus.
`timescale 1ns/1ps
module tb_adc_freq_meter;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 28;
  localparam int GC     = 1000;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic [DATA_W-1:0] adc_data = 8'd128;
  logic              sample_en = 1'b1;
  logic              square_out;
  logic [CNT_W-1:0]  freq_count;
  logic              freq_valid;
  logic              overflow;
  logic [CNT_W-1:0]  period_cycles;
  logic              period_valid;

  adc_freq_meter #(
    .DATA_W(DATA_W), .MID(128), .HYST(8), .GATE_CYCLES(GC), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .adc_data(adc_data), .sample_en(sample_en),
    .square_out(square_out), .freq_count(freq_count), .freq_valid(freq_valid),
    .overflow(overflow), .period_cycles(period_cycles), .period_valid(period_valid)
  );

  always #2 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int cnt;
    bit ovf;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   per_q[$];
  int   per_fixed = 0;
  int   per_seen  = 0;
  int   last_vld  = -1;
  int   checks    = 0;
  int   errors    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input int g);
    exp_t e;
    e.cnt = c;
    e.ovf = 1'b0;
    e.gap = g;
    sb.push_back(e);
  endtask

  // Monitor: compares every report the DUT presents against the scoreboard head.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_n) begin
      last_vld = -1;
    end else begin
      if (freq_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_freq_valid", freq_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("freq_count", freq_count, e.cnt);
          chk("overflow", overflow, e.ovf);
          if (e.gap != 0 && last_vld >= 0)
            chk("gate_spacing", cyc - last_vld, e.gap);
        end
        last_vld = cyc;
      end
      if (period_valid) begin
        per_seen++;
        if (per_fixed != 0)
          chk("period_cycles", period_cycles, per_fixed);
        else if (per_q.size() == 0)
          chk("unexpected_period_valid", period_valid, 0);
        else
          chk("period_cycles", period_cycles, per_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_n = 1'b0;
    repeat (3) step();
    RST_n = 1'b1;
  endtask

  // half==0 keeps adc_data constant; otherwise a 0/255 square wave of period 2*half.
  task automatic run_until_drained(input int half, input int maxc, input string name);
    for (int c = 0; c < maxc && sb.size() != 0; c++) begin
      if (half != 0)
        adc_data = ((c / half) % 2 == 0) ? 8'd255 : 8'd0;
      step();
    end
    chk(name, sb.size(), 0);
  endtask

  logic [7:0] hyst_in  [7] = '{8'd128, 8'd135, 8'd136, 8'd130, 8'd120, 8'd121, 8'd120};
  logic       hyst_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int nstale;
    int frozen_bad;

    // Reset held with random data
    RST_n = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      adc_data = 8'($urandom_range(0, 255));
      step();
    end
    chk("rst_square_out", square_out, 0);
    chk("rst_freq_count", freq_count, 0);
    chk("rst_freq_valid", freq_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_period_cycles", period_cycles, 0);
    chk("rst_period_valid", period_valid, 0);

    // No signal: a zero report once per gate
    adc_data = 8'd128;
    RST_n = 1'b1;
    push_exp(0, 0);
    push_exp(0, GC);
    push_exp(0, GC);
    run_until_drained(0, 3300, "nosignal_drained");

    // Hysteresis, one cycle of latency
    do_reset();
    for (int i = 0; i < 7; i++) begin
      adc_data = hyst_in[i];
      step();
      chk($sformatf("hyst_%0d", i), square_out, hyst_exp[i]);
    end

    // Reset in the middle of the gate opened above: nothing stale may appear
    adc_data = 8'd128;
    repeat (300) step();
    RST_n = 1'b0;
    repeat (2) step();
    RST_n = 1'b1;
    nstale = 0;
    repeat (800) begin
      step();
      if (freq_valid) nstale++;
    end
    chk("no_stale_freq_valid", nstale, 0);

    // 100-cycle square wave: the start edge is not counted, later gates see 10
    do_reset();
    adc_data = 8'd0;
    repeat (2) step();
    per_seen = 0;
`ifdef FREQ_PERIOD_MEAS_EN
    per_fixed = 100;
`endif
    push_exp(9, 0);
    push_exp(10, GC);
    push_exp(10, GC);
    run_until_drained(50, 3500, "square_drained");
    adc_data = 8'd128;
    repeat (200) step();
    chk("hold_freq_count", freq_count, 10);
    chk("hold_overflow", overflow, 0);
`ifdef FREQ_PERIOD_MEAS_EN
    chk("period_pulses_ge_29", (per_seen >= 29) ? 1 : 0, 1);
`else
    chk("period_pulses_absent", per_seen, 0);
`endif

    // Comparator frozen while sample_en=0 even though data toggles
    do_reset();
    per_fixed = 0;
    adc_data = 8'd0;
    repeat (2) step();
    adc_data = 8'd255;
    step();
    sample_en = 1'b0;
    push_exp(0, 0);
    push_exp(0, GC);
    frozen_bad = 0;
    for (int c = 0; c < 2500 && sb.size() != 0; c++) begin
      adc_data = ((c / 10) % 2 == 0) ? 8'd0 : 8'd255;
      step();
      if (square_out !== 1'b1) frozen_bad++;
    end
    chk("sample_en_drained", sb.size(), 0);
    chk("square_frozen_violations", frozen_bad, 0);
    sample_en = 1'b1;

    // Edges on the last GATE cycle (k=999) and on a LATCH cycle (k=2000)
    do_reset();
    adc_data = 8'd0;
    repeat (2) step();
`ifdef FREQ_PERIOD_MEAS_EN
    per_q.push_back(500);
    per_q.push_back(499);
    per_q.push_back(501);
    per_q.push_back(500);
`endif
    push_exp(2, 0);
    push_exp(1, GC);
    push_exp(1, GC);
    for (int k = 0; k < 3200 && sb.size() != 0; k++) begin
      adc_data = (k == 0 || k == 500 || k == 999 || k == 1500 || k == 2000) ? 8'd255 : 8'd0;
      step();
    end
    chk("edge_drained", sb.size(), 0);
    chk("period_q_drained", per_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
